// File: rtl/float_int_cvt_pkg.sv
// Shared core types: ALU ops, FP rounding modes, fflags layout.
// Also the stage bundles of the float-to-int converter.
package float_int_cvt_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_FCVT
  } alu_op_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_t;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  typedef struct packed {
    logic [31:0] op;
    logic        uns;
    rm_t         rm;
    logic [4:0]  tag;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic        nan;
    logic        sat;
    logic        uns;
    rm_t         rm;
    logic [4:0]  tag;
  } s2_t;

endpackage

// File: rtl/float_int_cvt_round.sv
// Round-increment decision for a sign/magnitude value.
// Reserved rounding modes fall through to truncation.
module fcvt_round
  import float_int_cvt_pkg::*;
(
  input  rm_t  rm,
  input  logic sign,
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  output logic increment
);

  // pick the increment for the active rounding mode
  always_comb begin
    increment = 1'b0;
    unique case (1'b1)
      rm == RM_RNE: increment = guard & (sticky | lsb);
      rm == RM_RDN: increment = sign & (guard | sticky);
      rm == RM_RUP: increment = ~sign & (guard | sticky);
      rm == RM_RMM: increment = guard;
      default:      increment = 1'b0;
    endcase
  end

endmodule

// File: rtl/float_int_cvt.sv
// FCVT.W.S / FCVT.WU.S: binary32 to 32-bit integer.
// Operand reg, align reg, result reg; valid/ready both sides.
module float_int_cvt
  import float_int_cvt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand,
  input  logic        is_unsigned,
  input  logic [2:0]  rm,
  input  logic [4:0]  tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags,
  output logic [4:0]  out_tag
);

  logic        s1_valid;
  logic        s2_valid;
  s1_t         s1;
  s2_t         s2;
  s2_t         s2_nxt;
  logic        out_adv;
  logic        load_s2;
  logic [7:0]  exp;
  logic [22:0] man;
  logic [23:0] sig;
  logic [7:0]  rsh;
  logic [7:0]  lsh;
  logic [55:0] ext;
  logic        inc;
  logic [32:0] rnd;
  logic [31:0] neg;
  logic        inexact;
  logic [31:0] res;
  logic        nv;
  logic        nx;
  logic [4:0]  ff;

  assign out_adv  = !out_valid || out_ready;
  assign load_s2  = !s2_valid || out_adv;
  assign in_ready = !s1_valid || !s2_valid || out_ready;

  // classify the operand and align it to integer + guard/sticky
  always_comb begin
    exp = s1.op[30:23];
    man = s1.op[22:0];
    sig = {1'b1, man};
    rsh = 8'd150 - exp;
    lsh = exp - 8'd150;
    ext = '0;
    s2_nxt = '0;
    s2_nxt.sign = s1.op[31];
    s2_nxt.uns  = s1.uns;
    s2_nxt.rm   = s1.rm;
    s2_nxt.tag  = s1.tag;
    s2_nxt.nan  = (exp == 8'hFF) && (man != '0);
    // -2^31 exactly is the one exponent-158 value that fits signed
    s2_nxt.sat  = ((exp == 8'hFF) && (man == '0))
               || (exp >= 8'd159)
               || (!s1.uns && (exp == 8'd158)
                   && !(s1.op[31] && (man == '0)));
    if (exp >= 8'd150) begin
      if (exp <= 8'd158)
        s2_nxt.mag = {8'b0, sig} << lsh;
    end else if (exp >= 8'd126) begin
      ext = {sig, 32'b0} >> rsh;
      s2_nxt.mag    = {8'b0, ext[55:32]};
      s2_nxt.guard  = ext[31];
      s2_nxt.sticky = |ext[30:0];
    end else begin
      s2_nxt.sticky = |s1.op[30:0];
    end
  end

  fcvt_round u_round (
    .rm        (s2.rm),
    .sign      (s2.sign),
    .lsb       (s2.mag[0]),
    .guard     (s2.guard),
    .sticky    (s2.sticky),
    .increment (inc)
  );

  // round, negate, saturate and form NV/NX
  always_comb begin
    rnd     = {1'b0, s2.mag} + {32'b0, inc};
    neg     = ~rnd[31:0] + 32'd1;
    inexact = s2.guard | s2.sticky;
    res     = '0;
    nv      = 1'b0;
    nx      = 1'b0;
    if (s2.nan) begin
      res = s2.uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      nv  = 1'b1;
    end else if (s2.uns) begin
      if (s2.sat) begin
        res = s2.sign ? 32'h0 : 32'hFFFF_FFFF;
        nv  = 1'b1;
      end else if (s2.sign) begin
        nv  = (rnd != '0);
        nx  = (rnd == '0) && inexact;
      end else if (rnd[32]) begin
        res = 32'hFFFF_FFFF;
        nv  = 1'b1;
      end else begin
        res = rnd[31:0];
        nx  = inexact;
      end
    end else begin
      if (s2.sat) begin
        res = s2.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        nv  = 1'b1;
      end else if (s2.sign) begin
        if (rnd > 33'h0_8000_0000) begin
          res = 32'h8000_0000;
          nv  = 1'b1;
        end else begin
          res = neg;
          nx  = inexact;
        end
      end else if (rnd > 33'h0_7FFF_FFFF) begin
        res = 32'h7FFF_FFFF;
        nv  = 1'b1;
      end else begin
        res = rnd[31:0];
        nx  = inexact;
      end
    end
    ff        = '0;
    ff[FF_NV] = nv;
    ff[FF_NX] = nx;
  end

  // operand stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.op  <= operand;
        s1.uns <= is_unsigned;
        s1.rm  <= rm_t'(rm);
        s1.tag <= tag;
      end
    end
  end

  // aligned stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (load_s2) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2 <= s2_nxt;
    end
  end

  // result register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      fflags    <= '0;
      out_tag   <= '0;
    end else if (out_adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result  <= res;
        fflags  <= ff;
        out_tag <= s2.tag;
      end
    end
  end

endmodule

// File: tb/tb_float_int_cvt.sv
// Directed bench for float_int_cvt.
// Hand-computed vectors, stall stream and reset flush.
module tb_float_int_cvt;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand;
  logic        is_unsigned;
  logic [2:0]  rm;
  logic [4:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic [4:0]  out_tag;

  int total;
  int bad;

  float_int_cvt dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operand     (operand),
    .is_unsigned (is_unsigned),
    .rm          (rm),
    .tag         (tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .fflags      (fflags),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fval(input int k);
    case (k)
      1: fval = 32'h3F80_0000;
      2: fval = 32'h4000_0000;
      3: fval = 32'h4040_0000;
      4: fval = 32'h4080_0000;
      5: fval = 32'h40A0_0000;
      6: fval = 32'h40C0_0000;
      7: fval = 32'h40E0_0000;
      default: fval = 32'h0000_0000;
    endcase
  endfunction

  task automatic do_op(
    input  logic [31:0] op,
    input  logic        uns,
    input  logic [2:0]  m,
    input  logic [4:0]  t,
    output logic [31:0] r,
    output logic [4:0]  f,
    output logic [4:0]  ot,
    output logic        got
  );
    @(negedge clk);
    in_valid = 1'b1;
    operand = op;
    is_unsigned = uns;
    rm = m;
    tag = t;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 1'b0;
    r = '0;
    f = '0;
    ot = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        r = result;
        f = fflags;
        ot = out_tag;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    total++;
    if ({result, fflags, out_tag} !== 42'h0) begin
      bad++;
      $display("FAIL reset_regs: result=%h fflags=%b tag=%0d want 0",
               result, fflags, out_tag);
    end
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic run_table(input int which, input int n);
    logic [31:0] op, er, r;
    logic [4:0]  ef, f, ot;
    logic        uns, got;
    logic [2:0]  m;
    for (int i = 0; i < n; i++) begin
      op = 0; uns = 0; m = 3'd0; er = 0; ef = 0;
      if (which == 0) begin
        case (i)
          0: begin op = 32'h3FC0_0000; m = 3'd0; er = 32'd2; ef = 5'h01; end
          1: begin op = 32'h4020_0000; m = 3'd0; er = 32'd2; ef = 5'h01; end
          2: begin op = 32'h4020_0000; m = 3'd4; er = 32'd3; ef = 5'h01; end
          3: begin op = 32'hC020_0000; m = 3'd2; er = 32'hFFFF_FFFD; ef = 5'h01; end
          4: begin op = 32'hC020_0000; m = 3'd3; er = 32'hFFFF_FFFE; ef = 5'h01; end
          5: begin op = 32'h3FC0_0000; m = 3'd7; er = 32'd1; ef = 5'h01; end
          6: begin op = 32'h0000_0001; m = 3'd3; er = 32'd1; ef = 5'h01; end
          7: begin op = 32'h8000_0000; m = 3'd0; er = 32'd0; ef = 5'h00; end
          8: begin op = 32'h3FC0_0000; m = 3'd1; er = 32'd1; ef = 5'h01; end
          default: begin op = 32'h4E80_0000; er = 32'h4000_0000; end
        endcase
      end else begin
        case (i)
          0: begin op = 32'h4F00_0000; er = 32'h7FFF_FFFF; ef = 5'h10; end
          1: begin op = 32'h4F00_0000; uns = 1; er = 32'h8000_0000; end
          2: begin op = 32'hCF00_0000; er = 32'h8000_0000; end
          3: begin op = 32'hFF80_0000; er = 32'h8000_0000; ef = 5'h10; end
          4: begin op = 32'h7F80_0000; uns = 1; er = 32'hFFFF_FFFF; ef = 5'h10; end
          5: begin op = 32'h5F80_0000; uns = 1; er = 32'hFFFF_FFFF; ef = 5'h10; end
          6: begin op = 32'h7FC0_0000; er = 32'h7FFF_FFFF; ef = 5'h10; end
          7: begin op = 32'h7F80_0001; uns = 1; er = 32'hFFFF_FFFF; ef = 5'h10; end
          8: begin op = 32'hBF00_0000; uns = 1; m = 3'd1; ef = 5'h01; end
          9: begin op = 32'hBF00_0000; uns = 1; m = 3'd2; ef = 5'h10; end
          10: begin op = 32'hC000_0000; uns = 1; m = 3'd1; ef = 5'h10; end
          11: begin op = 32'h4F80_0000; uns = 1; er = 32'hFFFF_FFFF; ef = 5'h10; end
          default: begin op = 32'hCF00_0001; er = 32'h8000_0000; ef = 5'h10; end
        endcase
      end
      do_op(op, uns, m, 5'(i), r, f, ot, got);
      total++;
      if (!got || r !== er || f !== ef || ot !== 5'(i)) begin
        bad++;
        $display("FAIL vec%0d_%0d op=%h: got=%b res=%h ff=%h tag=%0d want res=%h ff=%h tag=%0d",
                 which, i, op, got, r, f, ot, er, ef, i);
      end
    end
  endtask

  task automatic test_rounding;
    run_table(0, 10);
  endtask

  task automatic test_saturate;
    run_table(1, 13);
  endtask

  task automatic test_latency;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    operand = 32'h4040_0000;
    is_unsigned = 1'b0;
    rm = 3'd0;
    tag = 5'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: out_valid=%b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd3 || out_tag !== 5'd9) begin
      bad++;
      $display("FAIL latency_n2: valid=%b res=%h tag=%0d want 1 3 9",
               out_valid, result, out_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int sent, rcv, cyc;
    logic held_v, saw_low;
    logic [31:0] h_r;
    logic [4:0] h_f, h_t;
    sent = 0; rcv = 0; cyc = 0;
    held_v = 0; saw_low = 0;
    h_r = '0; h_f = '0; h_t = '0;
    while (rcv < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = (sent < 8);
      operand = fval(sent);
      tag = 5'(sent);
      rm = 3'd1;
      is_unsigned = 1'b0;
      #1;
      if (held_v) begin
        total++;
        if (!out_valid || {result, fflags, out_tag} !== {h_r, h_f, h_t}) begin
          bad++;
          $display("FAIL stall_hold cyc%0d: v=%b res=%h ff=%h tag=%0d want res=%h ff=%h tag=%0d",
                   cyc, out_valid, result, fflags, out_tag, h_r, h_f, h_t);
        end
      end
      held_v = out_valid && !out_ready;
      if (held_v) begin
        h_r = result; h_f = fflags; h_t = out_tag;
      end
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        total++;
        if (result !== 32'(rcv) || out_tag !== 5'(rcv) || fflags !== 5'h0) begin
          bad++;
          $display("FAIL stream%0d: res=%h tag=%0d ff=%h want %h %0d 0",
                   rcv, result, out_tag, fflags, rcv, rcv);
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rcv != 8) begin
      bad++;
      $display("FAIL stream_count: received=%0d want 8", rcv);
    end
    total++;
    if (!saw_low) begin
      bad++;
      $display("FAIL stream_backpressure: in_ready never 0, want a drop");
    end
  endtask

  task automatic test_reset_flush;
    logic leak;
    @(negedge clk);
    out_ready = 1'b0;
    rm = 3'd1;
    is_unsigned = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      operand = fval(i + 1);
      tag = 5'(20 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_full: out_valid=%b in_ready=%b want 1 0",
               out_valid, in_ready);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      bad++;
      $display("FAIL flush_async: out_valid=%b in_ready=%b res=%h want 0 1 0",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) leak = 1'b1;
    end
    total++;
    if (leak) begin
      bad++;
      $display("FAIL flush_stale: out_valid=1 after release, want 0");
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    operand = '0;
    is_unsigned = 1'b0;
    rm = '0;
    tag = '0;
    out_ready = 1'b1;
    total = 0;
    bad = 0;
    test_reset;
    test_rounding;
    test_saturate;
    test_latency;
    test_back_to_back;
    test_reset_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_int_cvt.md
FLOAT_INT_CVT -- requirements
Module: float_int_cvt

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit operand and result, 3-bit rm, 5-bit fflags).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand offered.
REQ-005 in_ready  output  1  block accepts operand this cycle.
REQ-006 operand  input  32  IEEE-754 binary32 source (FCVT rs1).
REQ-007 is_unsigned  input  1  0 = FCVT.W.S (signed), 1 = FCVT.WU.S (unsigned).
REQ-008 rm  input  3  resolved rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 SHALL be treated as RTZ.
REQ-009 tag  input  5  destination register index, passed through unchanged.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  32  converted integer.
REQ-013 fflags  output  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF SHALL always be 0.
REQ-014 out_tag  output  5  tag of the operation in result.

Function
REQ-015 Transfer SHALL occur on a side only when valid and ready are both 1 at a rising edge.
REQ-016 The datapath SHALL be a two-stage pipeline: S1 registers operand, classifies it (zero/subnormal/normal/inf/NaN) and aligns the 24-bit significand into a 32-bit integer plus guard and sticky; S2 rounds, negates, saturates and forms the flags.
REQ-017 Latency SHALL be 2: an operand accepted at edge N SHALL drive out_valid=1 after edge N+2 when out_ready was 1 throughout.
REQ-018 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-019 in_ready SHALL equal NOT s1_valid OR NOT s2_valid OR out_ready; a stage SHALL hold its contents while the stage downstream is full and not advancing.
REQ-020 result, fflags and out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Rounding: RNE ties-to-even, RTZ truncate, RDN toward -inf, RUP toward +inf, RMM ties-away, applied to magnitude using guard and sticky.
REQ-022 Signed out of range (rounded value > 2^31-1, or < -2^31) and +inf: result 0x7FFFFFFF (positive) or 0x80000000 (negative, -inf); NV=1, NX=0.
REQ-023 Unsigned: rounded value > 2^32-1 or +inf -> 0xFFFFFFFF, NV=1; rounded value < 0 or -inf -> 0x00000000, NV=1.
REQ-024 Any NaN (quiet or signalling) SHALL give 0x7FFFFFFF (signed) or 0xFFFFFFFF (unsigned), NV=1.
REQ-025 Negative input that rounds to 0 in unsigned mode SHALL give 0, NV=0, NX=1 if inexact.
REQ-026 NX SHALL be 1 iff the result is in range and guard or sticky is set; NX and NV SHALL never both be 1.
REQ-027 +0, -0 and subnormals SHALL convert as values of magnitude < 1 (zero inputs exact, flags 0).
REQ-028 Exponents >= 31+bias (signed) or >= 32+bias (unsigned) SHALL saturate without shifting.

Reset
REQ-029 While rst=0, s1_valid, s2_valid and out_valid SHALL be 0 and result, fflags, out_tag SHALL be 0.
REQ-030 in_ready SHALL be 1 during and immediately after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight operations with no result emitted.

Structure
REQ-032 The rounding-mode enum (rm_t) and fflags bit indices SHALL be defined in the shared package that defines alu_op_t.
REQ-033 The round/increment decision SHALL be a sub-module fcvt_round (inputs: rm, sign, lsb, guard, sticky; output: increment).

Verification
REQ-034 0x3FC00000 (1.5), signed, RNE -> 0x00000002, NX=1; 0x40200000 (2.5) RNE -> 2, RMM -> 3, both NX=1.
REQ-035 0xC0200000 (-2.5), signed, RDN -> 0xFFFFFFFD, NX=1; RUP -> 0xFFFFFFFE, NX=1.
REQ-036 0x4F000000 (2^31): signed -> 0x7FFFFFFF, NV=1; unsigned -> 0x80000000, flags 0; 0xCF000000 signed -> 0x80000000, flags 0.
REQ-037 0x7FC00000 signed -> 0x7FFFFFFF NV=1; 0xBF000000 (-0.5) unsigned RTZ -> 0 NX=1, RDN -> 0 NV=1.
REQ-038 Back-to-back stream of 8 operands with out_ready low for cycles 3-5 -> in_ready drops after both stages fill, no loss or reorder (out_tag sequence 0..7), each result stable while stalled.
REQ-039 rst asserted with both stages full -> out_valid=0 within the same cycle, no stale result after release.
